flash_sample_reader: RTL and testbench
======================================

Name: flash_sample_reader

Overview:
- Consumer side of the flash sample-address generator. It takes a sample index and fetches the 32-bit word that holds it from the flash controller over an Avalon-MM read-master interface.
- It returns the selected signed 16-bit audio sample to the audio output path.
- It caches the last fetched word, so the second sample of each word needs no flash access.
- Runs on CLK_50. The request strobe is already synchronised into clk by the caller.

Parameters:
- FLASH_ADDR_W, 23, width of the flash word address.
- TIMEOUT_CYCLES, 1024, maximum clk cycles from read acceptance to readdatavalid before the read aborts.
- UPPER_FIRST, 0, 0: sample index bit 0 = 0 selects readdata[15:0]; 1: the halves are swapped.

Ports:
- clk  in  1  system clock (CLK_50).
- reset_n  in  1  asynchronous, active-low reset.
- sample_req  in  1  single-cycle request strobe.
- sample_addr  in  32  sample index. Word address = sample_addr[FLASH_ADDR_W:1]; half select = sample_addr[0].
- flush  in  1  synchronous cache invalidate; pulse on playback restart or direction change.
- busy  out  1  high while a request is in progress.
- sample_valid  out  1  one-cycle strobe; sample_data is valid in that cycle.
- sample_data  out  16  returned sample, held until the next sample_valid.
- read_error  out  1  sticky; set on timeout.
- overrun  out  1  sticky; set when sample_req arrives while busy.
- flash_address  out  FLASH_ADDR_W  Avalon word address.
- flash_read  out  1  Avalon read.
- flash_byteenable  out  4  constant 4'b1111.
- flash_waitrequest  in  1  Avalon waitrequest.
- flash_readdata  in  32  Avalon read data.
- flash_readdatavalid  in  1  Avalon read data valid.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE; cache invalid.
  - busy, sample_valid, flash_read, read_error, overrun = 0.
  - sample_data and flash_address = 0.
- States: IDLE, LOOKUP, REQ, WAIT_DATA, RESPOND.
- IDLE:
  - On sample_req, latch sample_addr, set busy, go to LOOKUP.
- LOOKUP:
  - Hit = cache valid and cached word address equals the latched word address.
  - Hit: go to RESPOND.
  - Miss: drive flash_address, assert flash_read, go to REQ.
- REQ:
  - Hold flash_read and flash_address stable while flash_waitrequest = 1.
  - The first cycle with waitrequest = 0 accepts the read. In the next cycle flash_read = 0 and the state is WAIT_DATA with the timeout counter cleared.
- WAIT_DATA:
  - On flash_readdatavalid, store readdata as the cached word, mark the cache valid, go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES - 1 without readdatavalid:
    - invalidate the cache and set read_error;
    - return sample_data = 16'h0000 with sample_valid;
    - go to IDLE.
  - A readdatavalid arriving in IDLE after an abort is ignored.
- RESPOND:
  - sample_data = the selected half per UPPER_FIRST; pulse sample_valid for 1 cycle; clear busy; go to IDLE.
- Latency from sample_req to sample_valid:
  - hit: 3 cycles;
  - miss: 4 cycles + waitrequest cycles + readdatavalid latency.
- Request while busy: ignored; the current request completes unchanged; overrun = 1.
- Request in the same cycle that busy falls: busy is already 0 in IDLE, so the request is accepted.
- flush:
  - Invalidates the cache on the next edge in any state.
  - If flush coincides with a readdatavalid write, flush wins and the cache stays invalid. The in-flight sample is still returned.
- Address arithmetic:
  - Word address bits above FLASH_ADDR_W are dropped, with no error.
  - sample_addr = 32'hFFFFFFFF wraps naturally.
- flash_read is never asserted outside REQ, and only one read is outstanding at a time.

Decomposition:
- Shared package flash_audio_pkg holds:
  - state encoding constants;
  - FLASH_ADDR_W, last_addr, first_addr shared with the address generator;
  - the sample width of 16.
- One sub-module, flash_word_cache: holds the valid bit, word address and data word; provides hit compare, load and flush. Everything else stays in the top FSM.

Test Plan:
- Miss then hit:
  - req addr 0x10 with readdata 0xBEEF1234 and waitrequest 0: sample_data 0x1234 at 4 + 1 cycles.
  - req addr 0x11: sample 0xBEEF after 3 cycles, with no flash_read asserted.
- waitrequest held for 5 cycles:
  - flash_read and flash_address are stable throughout.
  - Exactly one accepted read; correct sample returned.
- Timeout:
  - Never assert readdatavalid: after TIMEOUT_CYCLES, sample_valid with 0x0000, read_error = 1, busy = 0.
  - A late readdatavalid afterwards causes no sample_valid.
- Overrun:
  - Second sample_req 2 cycles after the first: only one sample_valid, for the first address; overrun = 1.
- flush:
  - After the addr 0x10 fetch, pulse flush, then req 0x11: a new flash_read occurs (miss).
  - flush in the readdatavalid cycle: the next 0x11 request misses.
- Async reset mid-WAIT_DATA:
  - reset_n low: flash_read, busy and sample_valid drop immediately.
  - After release, a readdatavalid is ignored and the cache misses.

Source files
------------

// File: rtl/flash_audio_pkg.sv
// Shared definitions for the flash audio path: sample/address widths,
// playable index range and the sample reader state encoding.
`timescale 1ns/1ps
package flash_audio_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int SAMPLE_W     = 16;

    // Sample index range covered by the flash word address space.
    localparam logic [31:0] first_addr = 32'h0000_0000;
    localparam logic [31:0] last_addr  = 32'((64'd1 << (FLASH_ADDR_W + 1)) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

endpackage

// File: rtl/flash_word_cache.sv
// Single-entry cache of the last flash word fetched by the sample reader.
`timescale 1ns/1ps
module flash_word_cache #(
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              invalidate,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       word
);

    logic              valid;
    logic [ADDR_W-1:0] word_addr;

    // Data always loads so an in-flight sample survives a coincident invalidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid     <= 1'b0;
            word_addr <= '0;
            word      <= '0;
        end else begin
            if (load) begin
                word_addr <= load_addr;
                word      <= load_data;
            end
            if (invalidate)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
        end
    end

    assign hit = valid && (word_addr == lookup_addr);

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches the 32-bit flash word holding a sample index over Avalon-MM and
// returns the selected 16-bit half, reusing the last word when it matches.
`timescale 1ns/1ps
module flash_sample_reader #(
    parameter int FLASH_ADDR_W   = flash_audio_pkg::FLASH_ADDR_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit UPPER_FIRST    = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_req,
    input  logic [31:0]             sample_addr,
    input  logic                    flush,
    output logic                    busy,
    output logic                    sample_valid,
    output logic [15:0]             sample_data,
    output logic                    read_error,
    output logic                    overrun,
    output logic [FLASH_ADDR_W-1:0] flash_address,
    output logic                    flash_read,
    output logic [3:0]              flash_byteenable,
    input  logic                    flash_waitrequest,
    input  logic [31:0]             flash_readdata,
    input  logic                    flash_readdatavalid
);

    // state        | meaning
    // ST_IDLE      | waiting for sample_req
    // ST_LOOKUP    | compare latched word address with the cache
    // ST_REQ       | flash_read held until waitrequest drops
    // ST_WAIT_DATA | read accepted, waiting for readdatavalid or timeout
    // ST_RESPOND   | present the selected half, pulse sample_valid
    import flash_audio_pkg::*;

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [FLASH_ADDR_W-1:0] req_word;
    logic                    req_half;
    logic [TMR_W-1:0]        tmr;
    logic                    cache_hit;
    logic                    cache_load;
    logic                    cache_inval;
    logic [31:0]             cache_word;
    logic                    timeout;
    logic [SAMPLE_W-1:0]     sel_half;
    logic                    unused_addr_bits;

    assign flash_byteenable = 4'b1111;
    // Index bits above the flash word range are intentionally dropped.
    assign unused_addr_bits = ^sample_addr[31:FLASH_ADDR_W+1];

    assign cache_load  = (state == ST_WAIT_DATA) && flash_readdatavalid;
    assign timeout     = (state == ST_WAIT_DATA) && !flash_readdatavalid && (tmr == TMR_LAST);
    assign cache_inval = flush || timeout;
    assign sel_half    = (req_half ^ UPPER_FIRST) ? cache_word[31:16] : cache_word[15:0];

    flash_word_cache #(
        .ADDR_W(FLASH_ADDR_W)
    ) u_cache (
        .clk        (clk),
        .reset_n    (reset_n),
        .invalidate (cache_inval),
        .load       (cache_load),
        .load_addr  (req_word),
        .load_data  (flash_readdata),
        .lookup_addr(req_word),
        .hit        (cache_hit),
        .word       (cache_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            read_error    <= 1'b0;
            overrun       <= 1'b0;
            flash_read    <= 1'b0;
            flash_address <= '0;
            req_word      <= '0;
            req_half      <= 1'b0;
            tmr           <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_req && busy)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (sample_req) begin
                        req_word <= sample_addr[FLASH_ADDR_W:1];
                        req_half <= sample_addr[0];
                        busy     <= 1'b1;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        state <= ST_RESPOND;
                    end else begin
                        flash_address <= req_word;
                        flash_read    <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!flash_waitrequest) begin
                        flash_read <= 1'b0;
                        tmr        <= '0;
                        state      <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (flash_readdatavalid) begin
                        state <= ST_RESPOND;
                    end else if (tmr == TMR_LAST) begin
                        sample_data  <= '0;
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        read_error   <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_RESPOND: begin
                    sample_data  <= sel_half;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Randomised bench for flash_sample_reader: an Avalon flash responder plus a
// one-word cache model predicting data, latency and flash read count.
`timescale 1ns/1ps
module tb_flash_sample_reader;

    localparam int FW      = 23;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_req = 1'b0;
    logic [31:0]   sample_addr = '0;
    logic          flush_tb = 1'b0;
    logic          rsp_flush = 1'b0;
    logic          flush;
    logic          busy, sample_valid, read_error, overrun, flash_read;
    logic [15:0]   sample_data;
    logic [FW-1:0] flash_address;
    logic [3:0]    flash_byteenable;
    logic          flash_waitrequest = 1'b0;
    logic [31:0]   flash_readdata = '0;
    logic          flash_readdatavalid = 1'b0;

    int checks = 0;
    int errors = 0;

    assign flush = flush_tb | rsp_flush;

    flash_sample_reader #(
        .FLASH_ADDR_W(FW), .TIMEOUT_CYCLES(TIMEOUT), .UPPER_FIRST(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_req(sample_req), .sample_addr(sample_addr),
        .flush(flush), .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
        .read_error(read_error), .overrun(overrun), .flash_address(flash_address),
        .flash_read(flash_read), .flash_byteenable(flash_byteenable),
        .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
        .flash_readdatavalid(flash_readdatavalid)
    );

    always #10 clk = ~clk;

    // Flash contents, keyed by word address.
    function automatic logic [31:0] mem_word(input logic [FW-1:0] w);
        if (w == 23'h8) return 32'hBEEF1234;
        return ((32'(w) + 32'd1) * 32'h9E3779B1) ^ 32'h0F0F5A5A;
    endfunction

    function automatic logic [15:0] exp_sample(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a[FW:1]);
        return a[0] ? w[31:16] : w[15:0];
    endfunction

    // Reference cache: one valid word.
    bit            m_valid = 1'b0;
    logic [FW-1:0] m_word = '0;

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid && (m_word == a[FW:1]);
    endfunction

    // Avalon responder.
    int            cfg_wait = 0;
    int            cfg_lat = 1;
    bit            cfg_flush_rdv = 1'b0;
    int            acc_count = 0;
    bit            pend = 1'b0;
    int            pend_cnt = 0;
    logic [FW-1:0] pend_addr = '0;
    int            wait_left = 0;
    bit            in_read = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            flash_readdatavalid = 1'b0;
            rsp_flush = 1'b0;
            flash_readdata = $urandom;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    flash_readdatavalid = 1'b1;
                    flash_readdata = mem_word(pend_addr);
                    rsp_flush = cfg_flush_rdv;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (flash_read) begin
                if (!in_read) begin
                    in_read = 1'b1;
                    wait_left = cfg_wait;
                end
                if (wait_left > 0) begin
                    flash_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    flash_waitrequest = 1'b0;
                    acc_count++;
                    pend = 1'b1;
                    pend_cnt = cfg_lat;
                    pend_addr = flash_address;
                    in_read = 1'b0;
                end
            end else begin
                flash_waitrequest = 1'b0;
                in_read = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush_tb = 1'b1;
        tick();
        flush_tb = 1'b0;
        m_valid = 1'b0;
    endtask

    // Issue one request and follow it until sample_valid or the cycle bound.
    task automatic do_req(input logic [31:0] addr, input int bound, output bit got,
                          output logic [15:0] data, output int lat,
                          output int rd_cycles, output bit moved);
        logic [FW-1:0] prev;
        got = 1'b0; data = '0; lat = 0; rd_cycles = 0; moved = 1'b0; prev = '0;
        sample_addr = addr;
        sample_req = 1'b1;
        while (!got && lat < bound) begin
            tick();
            sample_req = 1'b0;
            lat++;
            if (flash_read) begin
                if (rd_cycles > 0 && flash_address !== prev) moved = 1'b1;
                prev = flash_address;
                rd_cycles++;
            end
            if (sample_valid) begin
                got = 1'b1;
                data = sample_data;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, sample_valid, flash_read, read_error, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, sample_valid, flash_read, read_error, overrun});
        end
        checks++;
        if (sample_data !== 16'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0000", sample_data);
        end
        checks++;
        if (flash_address !== '0) begin
            errors++; $display("FAIL reset_addr got=%h exp=0", flash_address);
        end
        checks++;
        if (flash_byteenable !== 4'hF) begin
            errors++; $display("FAIL byteenable got=%h exp=f", flash_byteenable);
        end
        reset_n = 1'b1;
        m_valid = 1'b0;
        tick();
    endtask

    task automatic test_miss_hit();
        bit got, mv; logic [15:0] d; int lat, rc, a0;
        cfg_wait = 0; cfg_lat = 1;
        a0 = acc_count;
        do_req(32'h10, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== 16'h1234) begin
            errors++; $display("FAIL miss_data got=%h valid=%0d exp=1234", d, got);
        end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL miss_latency got=%0d exp=5", lat); end
        checks++;
        if (acc_count - a0 != 1) begin
            errors++; $display("FAIL miss_reads got=%0d exp=1", acc_count - a0);
        end
        a0 = acc_count;
        do_req(32'h11, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== 16'hBEEF) begin
            errors++; $display("FAIL hit_data got=%h valid=%0d exp=beef", d, got);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL hit_latency got=%0d exp=3", lat); end
        checks++;
        if (rc != 0 || acc_count != a0) begin
            errors++; $display("FAIL hit_no_read got=%0d read cycles exp=0", rc);
        end
        m_valid = 1'b1; m_word = 23'h8;
    endtask

    task automatic test_waitrequest();
        bit got, mv; logic [15:0] d; int lat, rc, a0; logic [31:0] a;
        cfg_wait = 5; cfg_lat = 2;
        a = {8'($urandom), 23'h000123, 1'($urandom)};
        a0 = acc_count;
        do_req(a, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== exp_sample(a)) begin
            errors++; $display("FAIL wait_data got=%h exp=%h", d, exp_sample(a));
        end
        checks++;
        if (lat != 11) begin errors++; $display("FAIL wait_latency got=%0d exp=11", lat); end
        checks++;
        if (rc != 6 || mv) begin
            errors++; $display("FAIL wait_read_hold got=%0d cycles moved=%0d exp=6 0", rc, mv);
        end
        checks++;
        if (acc_count - a0 != 1) begin
            errors++; $display("FAIL wait_reads got=%0d exp=1", acc_count - a0);
        end
        m_valid = 1'b1; m_word = a[FW:1];
        cfg_wait = 0; cfg_lat = 1;
    endtask

    task automatic test_boundary();
        bit got, mv; logic [15:0] d; int lat, rc, a0;
        a0 = acc_count;
        do_req(32'hFFFF_FFFF, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== exp_sample(32'hFFFF_FFFF) || lat != 5) begin
            errors++;
            $display("FAIL wrap_top got=%h lat=%0d exp=%h lat=5", d, lat, exp_sample(32'hFFFF_FFFF));
        end
        m_valid = 1'b1; m_word = 23'h7FFFFF;
        do_req(32'h00FF_FFFE, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== exp_sample(32'h00FF_FFFE) || lat != 3 || acc_count - a0 != 1) begin
            errors++;
            $display("FAIL alias_hit got=%h lat=%0d reads=%0d exp=%h lat=3 reads=1",
                     d, lat, acc_count - a0, exp_sample(32'h00FF_FFFE));
        end
    endtask

    task automatic test_random();
        bit got, mv, hit; logic [15:0] d; int lat, rc, a0, exp_lat;
        logic [31:0] a; logic [FW-1:0] w;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) pulse_flush();
            cfg_wait = $urandom_range(0, 3);
            cfg_lat = $urandom_range(1, 4);
            w = ($urandom_range(0, 9) == 9) ? 23'h7FFFFF : 23'($urandom_range(0, 7));
            a = {8'($urandom), w, 1'($urandom)};
            hit = m_hit(a);
            exp_lat = hit ? 3 : 4 + cfg_wait + cfg_lat;
            a0 = acc_count;
            do_req(a, 100, got, d, lat, rc, mv);
            checks++;
            if (!got || d !== exp_sample(a)) begin
                errors++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", i, a, d, exp_sample(a));
            end
            checks++;
            if (lat != exp_lat) begin
                errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat);
            end
            checks++;
            if (acc_count - a0 != (hit ? 0 : 1)) begin
                errors++;
                $display("FAIL rand_reads[%0d] got=%0d exp=%0d", i, acc_count - a0, hit ? 0 : 1);
            end
            m_valid = 1'b1; m_word = w;
        end
        cfg_wait = 0; cfg_lat = 1;
    endtask

    task automatic test_flush();
        bit got, mv; logic [15:0] d; int lat, rc, a0;
        do_req(32'h10, 100, got, d, lat, rc, mv);
        pulse_flush();
        a0 = acc_count;
        do_req(32'h11, 100, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== 16'hBEEF || lat != 5 || acc_count - a0 != 1) begin
            errors++;
            $display("FAIL flush_miss got=%h lat=%0d reads=%0d exp=beef lat=5 reads=1",
                     d, lat, acc_count - a0);
        end
        cfg_flush_rdv = 1'b1;
        pulse_flush();
        do_req(32'h10, 100, got, d, lat, rc, mv);
        cfg_flush_rdv = 1'b0;
        checks++;
        if (!got || d !== 16'h1234) begin
            errors++; $display("FAIL flush_rdv_data got=%h exp=1234", d);
        end
        a0 = acc_count;
        do_req(32'h11, 100, got, d, lat, rc, mv);
        checks++;
        if (acc_count - a0 != 1 || d !== 16'hBEEF) begin
            errors++;
            $display("FAIL flush_rdv_miss reads=%0d data=%h exp reads=1 data=beef", acc_count - a0, d);
        end
        m_valid = 1'b1; m_word = 23'h8;
    endtask

    task automatic test_overrun();
        int nvalid, a0; logic [15:0] d; logic [31:0] a, b;
        a = {8'h00, 23'h000200, 1'b1};
        b = {8'h00, 23'h000300, 1'b0};
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_idle got=%b exp=0", overrun); end
        a0 = acc_count; nvalid = 0; d = '0;
        sample_addr = a; sample_req = 1'b1;
        tick(); sample_req = 1'b0;
        tick();
        sample_addr = b; sample_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(); sample_req = 1'b0;
            if (sample_valid) begin nvalid++; d = sample_data; end
        end
        checks++;
        if (nvalid != 1 || d !== exp_sample(a)) begin
            errors++;
            $display("FAIL overrun_result valids=%0d data=%h exp valids=1 data=%h", nvalid, d, exp_sample(a));
        end
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0 || acc_count - a0 != 1) begin
            errors++;
            $display("FAIL overrun_flag got=%b busy=%b reads=%0d exp=1 0 1", overrun, busy, acc_count - a0);
        end
        m_valid = 1'b1; m_word = a[FW:1];
    endtask

    task automatic test_timeout();
        bit got, mv; logic [15:0] d; int lat, rc, a0, late;
        logic [31:0] a;
        a = {8'h00, 23'h000400, 1'b0};
        checks++;
        if (read_error !== 1'b0) begin errors++; $display("FAIL err_idle got=%b exp=0", read_error); end
        cfg_lat = TIMEOUT + 5;
        do_req(a, TIMEOUT + 50, got, d, lat, rc, mv);
        checks++;
        if (!got || d !== 16'h0000 || lat != 3 + TIMEOUT) begin
            errors++;
            $display("FAIL timeout_resp valid=%0d data=%h lat=%0d exp=1 0000 %0d", got, d, lat, 3 + TIMEOUT);
        end
        checks++;
        if (read_error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_flags err=%b busy=%b exp=1 0", read_error, busy);
        end
        m_valid = 1'b0;
        late = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sample_valid) late++;
        end
        checks++;
        if (late != 0) begin errors++; $display("FAIL late_rdv valids=%0d exp=0", late); end
        cfg_lat = 1;
        a0 = acc_count;
        do_req(a, 100, got, d, lat, rc, mv);
        checks++;
        if (acc_count - a0 != 1 || d !== exp_sample(a)) begin
            errors++;
            $display("FAIL timeout_refetch reads=%0d data=%h exp=1 %h", acc_count - a0, d, exp_sample(a));
        end
        m_valid = 1'b1; m_word = a[FW:1];
    endtask

    task automatic test_async_reset();
        bit got, mv; logic [15:0] d; int lat, rc, a0, bad;
        logic [31:0] a;
        a = {8'h00, 23'h000500, 1'b1};
        cfg_lat = 12;
        sample_addr = a; sample_req = 1'b1;
        tick(); sample_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
        #4 reset_n = 1'b0;
        #1;
        checks++;
        if ({flash_read, busy, sample_valid, read_error, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL async_drop got=%b exp=00000", {flash_read, busy, sample_valid, read_error, overrun});
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        m_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sample_valid || busy) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_rdv activity=%0d exp=0", bad); end
        cfg_lat = 1;
        a0 = acc_count;
        do_req(a, 100, got, d, lat, rc, mv);
        checks++;
        if (acc_count - a0 != 1 || lat != 5 || d !== exp_sample(a)) begin
            errors++;
            $display("FAIL post_reset_miss reads=%0d lat=%0d data=%h exp=1 5 %h",
                     acc_count - a0, lat, d, exp_sample(a));
        end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_waitrequest();
        test_boundary();
        test_random();
        test_flush();
        test_overrun();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
